// File: rtl/multimode_shift_counter_pkg.sv
// Shared types and constants for the multimode shift counter.
// Mode encoding matches the 1-bit mode pin; direction constants match the dir pin.
// No logic here; imported by the top and the decoder.
package multimode_shift_counter_pkg;

  typedef enum logic {
    MODE_JOHNSON = 1'b0,
    MODE_RING    = 1'b1
  } mode_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/shift_counter_decode.sv
// Legality check and sequence-position decode for a Johnson or ring pattern.
// Purely combinational: index and illegal follow q and mode in the same cycle.
// No flow control; an illegal pattern always decodes to index 0.
module shift_counter_decode
  import multimode_shift_counter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(2*N)
) (
  input  logic [N-1:0]  q,
  input  mode_e         mode,
  output logic [IW-1:0] index,
  output logic          illegal
);

  // Compare q against every legal pattern of the selected mode; at most one matches.
  always_comb begin
    logic [N-1:0] pat;
    pat     = '0;
    index   = '0;
    illegal = 1'b1;
    if (mode == MODE_JOHNSON) begin
      for (int k = 0; k < 2*N; k++) begin
        // Positions 0..N fill ones from the LSB; N+1..2N-1 clear them again from the LSB.
        if (k <= N) pat = ~({N{1'b1}} << k);
        else        pat = {N{1'b1}} << (k - N);
        if (q == pat) begin
          index   = IW'(k);
          illegal = 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        pat = N'(1) << k;
        if (q == pat) begin
          index   = IW'(k);
          illegal = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/multimode_shift_counter.sv
// Johnson / ring shift counter with load, direction control and self-correction.
// Q and wrap update one clock after load/en; index and illegal are combinational from Q.
// No backpressure: every enabled edge advances, load overrides en.
module multimode_shift_counter
  import multimode_shift_counter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(2*N)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          en,
  input  logic          dir,
  input  logic          mode,
  input  logic          load,
  input  logic [N-1:0]  load_value,
  output logic [N-1:0]  Q,
  output logic [IW-1:0] index,
  output logic          wrap,
  output logic          illegal
);

  localparam logic [IW-1:0] JOHNSON_LAST = IW'(2*N - 1);
  localparam logic [IW-1:0] RING_LAST    = IW'(N - 1);

  mode_e         mode_sel;
  logic [N-1:0]  q_nxt;
  logic          wrap_nxt;
  logic [IW-1:0] last_idx;
  logic [N-1:0]  base;

  assign mode_sel = mode_e'(mode);
  assign last_idx = (mode_sel == MODE_JOHNSON) ? JOHNSON_LAST : RING_LAST;
  assign base     = (mode_sel == MODE_JOHNSON) ? '0 : N'(1);

  shift_counter_decode #(.N(N), .IW(IW)) u_decode (
    .q       (Q),
    .mode    (mode_sel),
    .index   (index),
    .illegal (illegal)
  );

  // Next-state mux: load beats en; an en step from an illegal pattern snaps to the mode base.
  always_comb begin
    q_nxt    = Q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = load_value;
    end else if (en) begin
      if (illegal) begin
        q_nxt = base;
      end else begin
        if (mode_sel == MODE_JOHNSON) begin
          if (dir == DIR_REV) q_nxt = {~Q[0], Q[N-1:1]};
          else                q_nxt = {Q[N-2:0], ~Q[N-1]};
        end else begin
          if (dir == DIR_REV) q_nxt = {Q[0], Q[N-1:1]};
          else                q_nxt = {Q[N-2:0], Q[N-1]};
        end
        wrap_nxt = (dir == DIR_REV) ? (index == '0) : (index == last_idx);
      end
    end
  end

  // State register and one-cycle wrap pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      Q    <= '0;
      wrap <= 1'b0;
    end else begin
      Q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_multimode_shift_counter.sv
// Directed and randomized bench for multimode_shift_counter at N = 5.
// Expected values come from a position-based model of the two sequences.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_multimode_shift_counter;

  localparam int N  = 5;
  localparam int IW = $clog2(2*N);

  logic          clock   = 1'b0;
  logic          reset_n = 1'b1;
  logic          en      = 1'b0;
  logic          dir     = 1'b0;
  logic          mode    = 1'b0;
  logic          load    = 1'b0;
  logic [N-1:0]  load_value = '0;
  logic [N-1:0]  Q;
  logic [IW-1:0] index;
  logic          wrap;
  logic          illegal;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_q    = '0;
  logic         exp_wrap = 1'b0;

  always #5 clock = ~clock;

  multimode_shift_counter #(.N(N)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .en         (en),
    .dir        (dir),
    .mode       (mode),
    .load       (load),
    .load_value (load_value),
    .Q          (Q),
    .index      (index),
    .wrap       (wrap),
    .illegal    (illegal)
  );

  // Period of the sequence for a mode.
  function automatic int m_period(input logic m);
    return m ? N : 2*N;
  endfunction

  // Pattern at sequence position k, built arithmetically.
  function automatic logic [N-1:0] m_val(input logic m, input int k);
    int v;
    if (m) v = 1 << k;
    else if (k <= N) v = (1 << k) - 1;
    else v = ((1 << N) - 1) - ((1 << (k - N)) - 1);
    return N'(v);
  endfunction

  // Position of q in the mode's sequence, -1 if it is not a member.
  function automatic int m_index(input logic [N-1:0] q, input logic m);
    for (int k = 0; k < m_period(m); k++)
      if (m_val(m, k) == q) return k;
    return -1;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    int idx;
    idx = m_index(exp_q, mode);
    cmp({tag, ".Q"}, 32'(Q), 32'(exp_q));
    cmp({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
    cmp({tag, ".illegal"}, 32'(illegal), 32'(idx < 0));
    cmp({tag, ".index"}, 32'(index), (idx < 0) ? 32'd0 : 32'(idx));
  endtask

  // One clock edge: advance the model with the current inputs, then check.
  task automatic step(input string tag);
    logic [N-1:0] nq;
    logic         nw;
    int           idx, p;
    nq  = exp_q;
    nw  = 1'b0;
    idx = m_index(exp_q, mode);
    p   = m_period(mode);
    if (load) begin
      nq = load_value;
    end else if (en) begin
      if (idx < 0) begin
        nq = mode ? N'(1) : '0;
      end else if (dir) begin
        nq = m_val(mode, (idx + p - 1) % p);
        nw = (idx == 0);
      end else begin
        nq = m_val(mode, (idx + 1) % p);
        nw = (idx == p - 1);
      end
    end
    @(posedge clock);
    #1;
    exp_q    = nq;
    exp_wrap = nw;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between edges; Q must clear before any edge.
  task automatic pulse_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q    = '0;
    exp_wrap = 1'b0;
    cmp({tag, ".async_q"}, 32'(Q), 32'd0);
    cmp({tag, ".async_wrap"}, 32'(wrap), 32'd0);
    #1;
    reset_n = 1'b1;
  endtask

  logic [N-1:0] j_fwd  [10] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
                                5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
  logic [N-1:0] r_fwd  [6]  = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

  initial begin
    // Power-on reset
    #1 reset_n = 1'b0;
    #1;
    cmp("reset.Q", 32'(Q), 32'd0);
    cmp("reset.wrap", 32'(wrap), 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    check_all("reset");

    // Johnson forward full period, wrap only after the tenth edge
    mode = 1'b0; dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step("jfwd");
      cmp("jfwd.tbl_q", 32'(Q), 32'(j_fwd[i]));
      cmp("jfwd.tbl_wrap", 32'(wrap), 32'(i == 9));
    end

    // Johnson reverse from zero wraps to the last position
    pulse_reset("jrev");
    dir = 1'b1;
    step("jrev");
    cmp("jrev.tbl_q", 32'(Q), 32'(5'b10000));
    cmp("jrev.tbl_index", 32'(index), 32'd9);
    cmp("jrev.tbl_wrap", 32'(wrap), 32'd1);
    en = 1'b0;
    step("jrev_hold");
    cmp("jrev.wrap_fall", 32'(wrap), 32'd0);

    // Ring mode after reset: illegal until the first step corrects Q
    pulse_reset("ring");
    mode = 1'b1; dir = 1'b0;
    #1;
    cmp("ring.illegal_after_reset", 32'(illegal), 32'd1);
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step("ring");
      cmp("ring.tbl_q", 32'(Q), 32'(r_fwd[i]));
      cmp("ring.tbl_wrap", 32'(wrap), 32'(i == 5));
    end

    // Illegal load in Johnson mode, then self-correction without wrap
    mode = 1'b0; en = 1'b0; load = 1'b1; load_value = 5'b00101;
    step("illegal_load");
    cmp("illegal_load.illegal", 32'(illegal), 32'd1);
    cmp("illegal_load.index", 32'(index), 32'd0);
    load = 1'b0; en = 1'b1; dir = 1'b1;
    step("correct");
    cmp("correct.q", 32'(Q), 32'd0);
    cmp("correct.wrap", 32'(wrap), 32'd0);

    // Load wins over en
    load = 1'b1; en = 1'b1; load_value = 5'b01111;
    step("load_pri");
    cmp("load_pri.q", 32'(Q), 32'(5'b01111));
    cmp("load_pri.index", 32'(index), 32'd4);

    // Hold, then asynchronous reset between edges
    load_value = 5'b00111;
    step("load_hold");
    load = 1'b0; en = 1'b0;
    step("hold1");
    step("hold2");
    cmp("hold.q", 32'(Q), 32'(5'b00111));
    pulse_reset("midreset");
    en = 1'b1; dir = 1'b0;
    step("after_reset");
    cmp("after_reset.q", 32'(Q), 32'(5'b00001));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) dir  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 19) == 0) mode = $urandom_range(0, 1) == 1;
      load_value = ($urandom_range(0, 1) == 1) ? N'($urandom)
                                                : m_val(mode, $urandom_range(0, m_period(mode) - 1));
      step("rand");
      if ($urandom_range(0, 59) == 0) pulse_reset("rand_reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
